reg_file_nzcv: RTL and testbench
================================

Name: reg_file_nzcv

Overview:
- Integer register file and NZCV flag register for the LEGv8 core; the stage directly upstream of the Alu.
- The two combinational read ports drive the Alu operand1/operand2 buses.
- The write port takes the Alu result (or load data) at writeback.
- The flag register captures the Alu flags output on flag-setting instructions (ADDS/SUBS/ANDS) and presents registered NZCV to branch-condition logic.

Parameters:
DATA_WIDTH, 64 (`REGDATASIZE), width of each register and of the data buses
NUM_REGS, 32, architectural registers X0..X31
ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH
FLAG_WIDTH, 4 (`FLAGSIZE), flag bits ordered {N,Z,C,V}, MSB = N
ZERO_REG, 31, index of XZR

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
read_reg1  input  ADDR_WIDTH  index for read port 1
read_reg2  input  ADDR_WIDTH  index for read port 2
read_data1  output  DATA_WIDTH  value of read_reg1; feeds Alu operand1
read_data2  output  DATA_WIDTH  value of read_reg2; feeds Alu operand2
write_enable  input  1  commit write_data to write_reg at next edge
write_reg  input  ADDR_WIDTH  destination index
write_data  input  DATA_WIDTH  writeback value (Alu result or load data)
set_flags  input  1  capture flags_in at next edge
flags_in  input  FLAG_WIDTH  Alu flags output
flags_out  output  FLAG_WIDTH  registered NZCV

Behaviour:
- Storage:
  - NUM_REGS-1 physical registers, X0..X30.
  - X31 is XZR with no storage: reads return 0; writes to X31 are silently dropped.
- Reset:
  - reset sampled high at a rising edge clears X0..X30 and flags_out to 0.
  - After reset, every read returns 0 and flags_out = 4'b0000.
  - Reset is synchronous only. Assertion between edges changes nothing until the next edge.
- Reset priority:
  - While reset is high, write_enable and set_flags are ignored; reset wins over simultaneous write/flag capture.
  - Bypass is also suppressed while reset is high, so reads return the stored value.
  - Asserting reset mid-sequence discards any pending write in that cycle.
- Reads:
  - Combinational, zero latency; read_dataN follows read_regN within the same cycle.
  - Both ports may address the same register.
- Write:
  - write_enable=1 and write_reg!=ZERO_REG at a rising edge: register[write_reg] <= write_data.
  - write_enable=0: no state change. Exactly one write per cycle.
- Write-to-read bypass:
  - Applies when reset=0, write_enable=1, write_reg==read_regN and read_regN!=ZERO_REG.
  - Under those conditions read_dataN = write_data combinationally in the same cycle, giving write-first semantics across the writeback/decode boundary.
  - Applied independently per port.
  - Never bypasses onto XZR.
- Flags:
  - set_flags=1 (reset=0) at an edge: flags_out <= flags_in. Otherwise flags_out holds.
  - No bypass: flags written in cycle t are visible on flags_out from cycle t+1.
  - set_flags and a register write in the same cycle are independent and both commit.
- Widths: no arithmetic inside; write_data is stored as-is (no sign/zero extension). Index comparisons are full ADDR_WIDTH bit compares.
- No X propagation: reads of never-written registers after reset return 0.

Test Plan:
1. Reset, then read all indices 0..31 on both ports -> every read_data = 0, flags_out = 4'b0000.
2. Write X5 = 64'd20 and X6 = 64'd4 on successive edges; then read_reg1=5, read_reg2=6 -> read_data1=20, read_data2=4. Drive Alu SUB and write the result to X7 -> X7 reads 64'd16.
3. Same cycle: write_enable=1, write_reg=3, write_data=64'hDEAD_BEEF, read_reg1=3 -> read_data1 = 64'hDEAD_BEEF before the edge (bypass) and after it (stored). Same with write_reg=31, read_reg1=31 -> read_data1 = 0 both before and after.
4. set_flags=1, flags_in=4'b0110 -> flags_out stays 0 in that cycle and is 4'b0110 next cycle. Then set_flags=0, flags_in=4'b1001 -> flags_out holds 4'b0110.
5. Write X10 = -64'd16 (64'hFFFF_FFFF_FFFF_FFF0) -> readback is bit-exact on both ports simultaneously.
6. With X10 non-zero, assert reset together with write_enable=1, write_reg=10, write_data=64'd99 and set_flags=1 -> after the edge X10 = 0, flags_out = 0, and read_data shows no bypass of 99 during the reset cycle.

Source files
------------

// File: rtl/reg_file_nzcv.sv
// Integer register file (X0..X30 plus hardwired XZR) and the NZCV flag register.
// Two combinational read ports with write-to-read bypass; one write port.
module reg_file_nzcv #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_REGS   = 2 ** ADDR_WIDTH,
    parameter int unsigned FLAG_WIDTH = 4,
    parameter int unsigned ZERO_REG   = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  set_flags,
    input  logic [FLAG_WIDTH-1:0] flags_in,
    output logic [FLAG_WIDTH-1:0] flags_out
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

    // XZR has no storage, so only NUM_REGS-1 physical registers exist
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS-1];
    logic [FLAG_WIDTH-1:0] flags_q;

    logic wr_active;
    logic bypass1;
    logic bypass2;

    // A write is live only outside reset and never to XZR
    always_comb begin
        wr_active = write_enable && !reset && (write_reg != ZERO_IDX);
        bypass1   = wr_active && (write_reg == read_reg1);
        bypass2   = wr_active && (write_reg == read_reg2);
    end

    // Register storage: reset clears everything and overrides any write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_active) begin
            regs_q[write_reg] <= write_data;
        end
    end

    // Flag register: captures Alu flags on flag-setting instructions only
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
        end else if (set_flags) begin
            flags_q <= flags_in;
        end
    end

    // Read port 1: XZR reads zero, bypass gives write-first semantics
    always_comb begin
        read_data1 = '0;
        if (bypass1) begin
            read_data1 = write_data;
        end else if (read_reg1 != ZERO_IDX) begin
            read_data1 = regs_q[read_reg1];
        end
    end

    // Read port 2: same behaviour as port 1, applied independently
    always_comb begin
        read_data2 = '0;
        if (bypass2) begin
            read_data2 = write_data;
        end else if (read_reg2 != ZERO_IDX) begin
            read_data2 = regs_q[read_reg2];
        end
    end

    assign flags_out = flags_q;

endmodule

// File: tb/tb_reg_file_nzcv.sv
// Directed self-checking bench for reg_file_nzcv.
module tb_reg_file_nzcv;

    logic        clk;
    logic        reset;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [63:0] read_data1;
    logic [63:0] read_data2;
    logic        write_enable;
    logic [4:0]  write_reg;
    logic [63:0] write_data;
    logic        set_flags;
    logic [3:0]  flags_in;
    logic [3:0]  flags_out;

    int checks = 0;
    int errors = 0;

    reg_file_nzcv dut (
        .clk          (clk),
        .reset        (reset),
        .read_reg1    (read_reg1),
        .read_reg2    (read_reg2),
        .read_data1   (read_data1),
        .read_data2   (read_data2),
        .write_enable (write_enable),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .set_flags    (set_flags),
        .flags_in     (flags_in),
        .flags_out    (flags_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] op_a;
    logic [63:0] op_b;

    initial begin
        reset        = 1'b1;
        read_reg1    = '0;
        read_reg2    = '0;
        write_enable = 1'b0;
        write_reg    = '0;
        write_data   = '0;
        set_flags    = 1'b0;
        flags_in     = '0;
        step();
        step();
        reset = 1'b0;

        // 1: every index reads zero after reset on both ports
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i);
            read_reg2 = 5'(31 - i);
            #1;
            check_val($sformatf("rst_rd1_x%0d", i), read_data1, 64'd0);
            check_val($sformatf("rst_rd2_x%0d", 31 - i), read_data2, 64'd0);
        end
        check_val("rst_flags", {60'd0, flags_out}, 64'd0);

        // 2: write operands, read both, write the difference back
        op_a = 64'd20;
        op_b = 64'd4;
        write_enable = 1'b1;
        write_reg    = 5'd5;
        write_data   = op_a;
        step();
        write_reg  = 5'd6;
        write_data = op_b;
        step();
        write_enable = 1'b0;
        read_reg1    = 5'd5;
        read_reg2    = 5'd6;
        #1;
        check_val("x5_read", read_data1, 64'd20);
        check_val("x6_read", read_data2, 64'd4);
        write_enable = 1'b1;
        write_reg    = 5'd7;
        write_data   = op_a - op_b;
        step();
        write_enable = 1'b0;
        read_reg1    = 5'd7;
        #1;
        check_val("x7_sub", read_data1, 64'd16);

        // 3: bypass on a normal register; other port unaffected
        write_enable = 1'b1;
        write_reg    = 5'd3;
        write_data   = 64'hDEAD_BEEF;
        read_reg1    = 5'd3;
        read_reg2    = 5'd5;
        #1;
        check_val("x3_bypass", read_data1, 64'hDEAD_BEEF);
        check_val("x5_nobypass", read_data2, 64'd20);
        step();
        write_enable = 1'b0;
        write_data   = 64'd0;
        #1;
        check_val("x3_stored", read_data1, 64'hDEAD_BEEF);
        // never bypass or store onto XZR
        write_enable = 1'b1;
        write_reg    = 5'd31;
        write_data   = 64'h1234_5678;
        read_reg1    = 5'd31;
        read_reg2    = 5'd31;
        #1;
        check_val("xzr_bypass1", read_data1, 64'd0);
        check_val("xzr_bypass2", read_data2, 64'd0);
        step();
        write_enable = 1'b0;
        #1;
        check_val("xzr_after", read_data1, 64'd0);

        // 4: flags have no bypass, hold when set_flags=0; write in same cycle also commits
        set_flags    = 1'b1;
        flags_in     = 4'b0110;
        write_enable = 1'b1;
        write_reg    = 5'd8;
        write_data   = 64'h55;
        #1;
        check_val("flags_same_cycle", {60'd0, flags_out}, 64'd0);
        step();
        set_flags    = 1'b0;
        write_enable = 1'b0;
        flags_in     = 4'b1001;
        read_reg1    = 5'd8;
        #1;
        check_val("flags_captured", {60'd0, flags_out}, 64'h6);
        check_val("x8_with_flags", read_data1, 64'h55);
        step();
        check_val("flags_hold", {60'd0, flags_out}, 64'h6);

        // 5: negative value stored bit-exact, both ports on the same register
        write_enable = 1'b1;
        write_reg    = 5'd10;
        write_data   = 64'hFFFF_FFFF_FFFF_FFF0;
        step();
        write_enable = 1'b0;
        read_reg1    = 5'd10;
        read_reg2    = 5'd10;
        #1;
        check_val("x10_rd1", read_data1, 64'hFFFF_FFFF_FFFF_FFF0);
        check_val("x10_rd2", read_data2, 64'hFFFF_FFFF_FFFF_FFF0);

        // 6: reset beats simultaneous write and flag capture, and suppresses bypass
        reset        = 1'b1;
        write_enable = 1'b1;
        write_reg    = 5'd10;
        write_data   = 64'd99;
        set_flags    = 1'b1;
        flags_in     = 4'b1111;
        read_reg2    = 5'd5;
        #1;
        check_val("rst_no_bypass", read_data1, 64'hFFFF_FFFF_FFFF_FFF0);
        check_val("rst_flags_pre", {60'd0, flags_out}, 64'h6);
        step();
        reset        = 1'b0;
        write_enable = 1'b0;
        set_flags    = 1'b0;
        #1;
        check_val("x10_after_rst", read_data1, 64'd0);
        check_val("x5_after_rst", read_data2, 64'd0);
        check_val("flags_after_rst", {60'd0, flags_out}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
